// File: rtl/x1_wb_initiator.sv
// x1_wb_initiator: Wishbone classic master for the Neuromorphic X1 bit array.
// It takes PROGRAM/READ requests from a host port and encodes each one as a
// command word written to a single address. For READs it polls that same
// address until a value other than the DEAD_C0DE empty marker comes back,
// then returns one response per request.
//
// Host handshakes: a request moves on a clock edge where req_valid and
// req_ready are both high. A response moves on a clock edge where rsp_valid
// and rsp_ready are both high. rsp_valid, rsp_bit and rsp_status stay stable
// until that edge. The request fields only need to be valid at the accept
// edge.
module x1_wb_initiator #(
    parameter logic [31:0] ADDR_MATCH = 32'h3000_000C,
    parameter int          POLL_GAP   = 8,
    parameter int          POLL_MAX   = 1024,
    parameter int          ACK_TMO    = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [4:0]  req_row,
    input  logic [4:0]  req_col,
    input  logic [7:0]  req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_bit,
    output logic [1:0]  rsp_status,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic [2:0]  o_dbg_state
);

    localparam int GAP_W = $clog2(POLL_GAP + 1);
    localparam int TMO_W = $clog2(ACK_TMO + 1);

    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(POLL_GAP - 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(ACK_TMO - 1);
    localparam logic [15:0]      POLL_LIMIT = 16'(POLL_MAX);
    localparam logic [31:0]      EMPTY_WORD = 32'hDEAD_C0DE;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_POLL_EXH = 2'b01;
    localparam logic [1:0] ST_ACK_TMO  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_GAP  = 3'd2,
        S_POLL = 3'd3,
        S_RSP  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_cmd;
    logic              r_is_prog;
    logic [15:0]       r_poll_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_rsp_bit;
    logic [1:0]        r_rsp_status;

    logic              w_accept;
    logic              w_stb;
    logic              w_tmo_hit;
    logic              w_is_empty;
    logic [15:0]       w_poll_cnt_nxt;
    logic [31:0]       w_cmd;
    logic              w_rsp_load;
    logic              w_rsp_bit_nxt;
    logic [1:0]        w_rsp_status_nxt;

    // The bus is driven directly from the state so that an asynchronous
    // reset drops cyc/stb at once.
    assign w_stb       = (r_state == S_CMD) || (r_state == S_POLL);
    assign wbm_cyc_o   = w_stb;
    assign wbm_stb_o   = w_stb;
    assign wbm_we_o    = (r_state == S_CMD);
    assign wbm_sel_o   = 4'hF;
    assign wbm_adr_o   = ADDR_MATCH;
    assign wbm_dat_o   = r_cmd;
    assign req_ready   = (r_state == S_IDLE);
    assign rsp_valid   = (r_state == S_RSP);
    assign rsp_bit     = r_rsp_bit;
    assign rsp_status  = r_rsp_status;
    assign o_dbg_state = r_state;

    assign w_accept       = req_valid && (r_state == S_IDLE);
    assign w_tmo_hit      = w_stb && !wbm_ack_i && (r_tmo_cnt == TMO_LAST);
    assign w_is_empty     = (wbm_dat_i == EMPTY_WORD);
    assign w_poll_cnt_nxt = r_poll_cnt + 16'd1;
    // Command word layout: mode, row, col, twelve zero bits, then the data byte.
    // READ requests carry a zero data byte.
    assign w_cmd = {(req_op ? 2'b11 : 2'b01), req_row, req_col, 12'h000,
                    (req_op ? req_data : 8'h00)};

    // Next-state logic and the response value captured when entering RSP.
    always_comb begin
        w_next_state     = r_state;
        w_rsp_load       = 1'b0;
        w_rsp_bit_nxt    = 1'b0;
        w_rsp_status_nxt = ST_OK;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next_state = S_CMD;
            end
            S_CMD: begin
                if (wbm_ack_i) begin
                    if (r_is_prog) begin
                        w_next_state = S_RSP;
                        w_rsp_load   = 1'b1;
                    end else begin
                        w_next_state = S_GAP;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state     = S_RSP;
                    w_rsp_load       = 1'b1;
                    w_rsp_status_nxt = ST_ACK_TMO;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next_state = S_POLL;
            end
            S_POLL: begin
                if (wbm_ack_i) begin
                    if (!w_is_empty) begin
                        w_next_state  = S_RSP;
                        w_rsp_load    = 1'b1;
                        w_rsp_bit_nxt = wbm_dat_i[0];
                    end else if (w_poll_cnt_nxt == POLL_LIMIT) begin
                        w_next_state     = S_RSP;
                        w_rsp_load       = 1'b1;
                        w_rsp_status_nxt = ST_POLL_EXH;
                    end else begin
                        w_next_state = S_GAP;
                    end
                end else if (w_tmo_hit) begin
                    w_next_state     = S_RSP;
                    w_rsp_load       = 1'b1;
                    w_rsp_status_nxt = ST_ACK_TMO;
                end
            end
            S_RSP: begin
                if (rsp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) r_state <= S_IDLE;
        else             r_state <= w_next_state;
    end

    // Latch the request when it is accepted and capture the response value.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cmd        <= 32'h0;
            r_is_prog    <= 1'b0;
            r_rsp_bit    <= 1'b0;
            r_rsp_status <= ST_OK;
        end else begin
            if (w_accept) begin
                r_cmd     <= w_cmd;
                r_is_prog <= req_op;
            end
            if (w_rsp_load) begin
                r_rsp_bit    <= w_rsp_bit_nxt;
                r_rsp_status <= w_rsp_status_nxt;
            end
        end
    end

    // Counters. The timeout counter runs while a transfer waits and clears
    // whenever the state moves on. The gap counter runs only inside GAP. The
    // poll counter counts acked result reads of the current request.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_poll_cnt <= 16'd0;
        end else begin
            if (w_stb && (w_next_state == r_state)) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            else                                    r_tmo_cnt <= '0;

            if ((r_state == S_GAP) && (w_next_state == S_GAP)) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            else                                               r_gap_cnt <= '0;

            if (w_accept)                             r_poll_cnt <= 16'd0;
            else if ((r_state == S_POLL) && wbm_ack_i) r_poll_cnt <= w_poll_cnt_nxt;
        end
    end

endmodule
